// File: rtl/inst_server_pkg.sv
// Shared definitions for the instruction server: default address width,
// loader state encoding and big-endian word assembly.
package inst_server_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_e;

  // First three bytes sit in the shift register; the fourth arrives live.
  function automatic logic [31:0] be_word(input logic [23:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/inst_bram.sv
// Single-port-write, registered-read instruction store with read-first
// behaviour; coded so synthesis maps it onto block RAM.
module inst_bram
  import inst_server_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  // NOTE: the array has no reset so it stays a RAM macro; only the output
  // register is cleared, which block RAMs support natively.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Non-blocking read of the array yields the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_server.sv
// Byte-stream program loader feeding an instruction memory: a 4-byte
// big-endian word count, then that many big-endian words, then run.
module inst_server
  import inst_server_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_data,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_shift;
  logic [31:0]       r_n;
  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_load_done;
  logic              r_load_err;

  logic              w_fire;
  logic              w_last_byte;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_hdr_err;
  logic              w_we;
  logic              w_set_err;

  assign rx_ready    = (r_state != DONE);
  assign w_fire      = rx_valid && rx_ready;
  assign w_last_byte = w_fire && (r_byte_idx == 2'd3);
  assign w_word      = be_word(r_shift, rx_data);
  assign w_cnt_inc   = r_word_cnt + 1'b1;
  assign w_hdr_err   = ({1'b0, w_word} > DEPTH);

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      HDR: begin
        if (w_last_byte) begin
          if (w_word == 32'd0) begin
            w_state_nxt = DONE;
          end else if (w_hdr_err) begin
            w_state_nxt = DONE;
            w_set_err   = 1'b1;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_last_byte) begin
          w_we = 1'b1;
          if (32'(w_cnt_inc) == r_n) w_state_nxt = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= HDR;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_n         <= '0;
      r_word_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      if (w_fire) begin
        r_byte_idx <= r_byte_idx + 1'b1;
        r_shift    <= {r_shift[15:0], rx_data};
      end
      if (r_state == HDR && w_last_byte) begin
        r_n        <= w_word;
        r_word_cnt <= '0;
        r_wr_ptr   <= '0;
      end
      if (w_we) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_word_cnt <= w_cnt_inc;
      end
      if (w_state_nxt == DONE) r_load_done <= 1'b1;
      if (w_set_err)           r_load_err  <= 1'b1;
    end
  end

  assign load_done = r_load_done;
  assign load_err  = r_load_err;

  inst_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_word),
    .i_raddr (inst_addr),
    .o_rdata (inst_data)
  );

endmodule

// File: tb/tb_inst_server.sv
// Directed bench for inst_server: a default-width instance for the main
// load scenarios and an ADDR_W=2 instance for the full-depth boundary.
module tb_inst_server;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inst_addr = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_v = 1'b0;
  logic        sel_small = 1'b0;

  logic        rx_valid_a, rx_valid_b;
  logic [31:0] inst_data_a, inst_data_b;
  logic        rx_ready_a, rx_ready_b;
  logic        load_done_a, load_done_b;
  logic        load_err_a, load_err_b;

  int n_tests = 0;
  int n_fail  = 0;

  assign rx_valid_a = rx_v && !sel_small;
  assign rx_valid_b = rx_v && sel_small;

  always #5 clk = ~clk;

  inst_server dut (
    .clk       (clk),
    .rst       (rst),
    .inst_addr (inst_addr),
    .inst_data (inst_data_a),
    .rx_valid  (rx_valid_a),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready_a),
    .load_done (load_done_a),
    .load_err  (load_err_a)
  );

  inst_server #(.ADDR_W(2)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .inst_addr (inst_addr[1:0]),
    .inst_data (inst_data_b),
    .rx_valid  (rx_valid_b),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready_b),
    .load_done (load_done_b),
    .load_err  (load_err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rx_v = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_v = 1'b0;
    repeat (gap) tick();
    rx_data = b;
    rx_v    = 1'b1;
    tick();
    rx_v    = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic read_a(input logic [15:0] a, input logic [31:0] exp, input string tag);
    inst_addr = a;
    tick();
    check(tag, inst_data_a, exp);
  endtask

  task automatic read_b(input logic [15:0] a, input logic [31:0] exp, input string tag);
    inst_addr = a;
    tick();
    check(tag, inst_data_b, exp);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_inst_data", inst_data_a, 32'h0);
    check("rst_load_done", {31'd0, load_done_a}, 32'd0);
    check("rst_load_err",  {31'd0, load_err_a},  32'd0);
    check("rst_rx_ready",  {31'd0, rx_ready_a},  32'd1);
    rst = 1'b0;

    // Two-word load with gaps; load_done must rise right after byte 12
    send_word(32'h0000_0002, 2);
    send_word(32'h1234_5678, 1);
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 3);
    send_byte(8'hDE, 0);
    check("two_done_before_last", {31'd0, load_done_a}, 32'd0);
    send_byte(8'hF0, 2);
    check("two_done_after_last", {31'd0, load_done_a}, 32'd1);
    check("two_err", {31'd0, load_err_a}, 32'd0);
    check("two_rx_ready_done", {31'd0, rx_ready_a}, 32'd0);
    read_a(16'd0, 32'h1234_5678, "two_mem0");
    read_a(16'd1, 32'h9ABC_DEF0, "two_mem1");
    // Bytes offered in DONE are dropped
    send_word(32'h5555_5555, 0);
    read_a(16'd0, 32'h1234_5678, "done_ignore_mem0");
    read_a(16'd1, 32'h9ABC_DEF0, "done_ignore_mem1");

    // Zero-length program
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("zero_done_before", {31'd0, load_done_a}, 32'd0);
    send_byte(8'h00, 0);
    check("zero_done", {31'd0, load_done_a}, 32'd1);
    check("zero_err",  {31'd0, load_err_a},  32'd0);
    read_a(16'd0, 32'h1234_5678, "zero_no_write");

    // Oversized header: 0x00010001 > 65536
    do_reset();
    send_word(32'h0001_0001, 0);
    check("big_err",  {31'd0, load_err_a},  32'd1);
    check("big_done", {31'd0, load_done_a}, 32'd1);
    check("big_rx_ready", {31'd0, rx_ready_a}, 32'd0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'hEEEE_EEEE, 1);
    check("big_err_sticky", {31'd0, load_err_a}, 32'd1);
    read_a(16'd0, 32'h1234_5678, "big_no_write0");
    read_a(16'd1, 32'h9ABC_DEF0, "big_no_write1");

    // Read-first collision at address 0
    do_reset();
    send_word(32'h0000_0001, 0);
    send_word(32'h1111_1111, 0);
    read_a(16'd0, 32'h1111_1111, "rf_setup");
    do_reset();
    inst_addr = 16'd0;
    send_word(32'h0000_0001, 0);
    send_word(32'hCAFE_F00D, 0);
    check("rf_old_value", inst_data_a, 32'h1111_1111);
    tick();
    check("rf_new_value", inst_data_a, 32'hCAFE_F00D);

    // Aborted load with random gaps, then a clean one-word load
    do_reset();
    send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'h02, $urandom_range(0, 2));
    send_byte(8'hAA, $urandom_range(0, 2));
    send_byte(8'hBB, $urandom_range(0, 2));
    do_reset();
    send_word(32'h0000_0001, 0);
    send_word(32'hDEAD_BEEF, 0);
    check("abort_done", {31'd0, load_done_a}, 32'd1);
    check("abort_err",  {31'd0, load_err_a},  32'd0);
    read_a(16'd0, 32'hDEAD_BEEF, "abort_mem0");
    read_a(16'd1, 32'h9ABC_DEF0, "abort_mem1");

    // Small instance: N equal to full depth (4) must terminate
    sel_small = 1'b1;
    do_reset();
    send_word(32'h0000_0004, 0);
    send_word(32'hA000_0000, 1);
    send_word(32'hA000_0001, 0);
    send_word(32'hA000_0002, 2);
    send_byte(8'hA0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("full_done_before", {31'd0, load_done_b}, 32'd0);
    send_byte(8'h03, 0);
    check("full_done", {31'd0, load_done_b}, 32'd1);
    check("full_err",  {31'd0, load_err_b},  32'd0);
    read_b(16'd0, 32'hA000_0000, "full_mem0");
    read_b(16'd3, 32'hA000_0003, "full_mem3");

    // Small instance: N = depth + 1 is rejected
    do_reset();
    send_word(32'h0000_0005, 0);
    check("over_err",  {31'd0, load_err_b},  32'd1);
    check("over_done", {31'd0, load_done_b}, 32'd1);
    send_word(32'h7777_7777, 0);
    read_b(16'd0, 32'hA000_0000, "over_no_write");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
